ternary_system: RTL and testbench
=================================

// Module: ternary_system
// PURPOSE
// - Top-level ternary computer: system FSM, program loader, unified word memory, and the existing `cpu` core.
// - On a start pulse it copies a boot program from loader ROM into memory, then releases the CPU to execute it.
// - Word = 9 balanced trits = 18 bits; trit i occupies bits [2i+1:2i].
// - Trit codes are `_1 = 2'b00 (-1), `_0 = 2'b01 (0) and `_1_ = 2'b10 (+1); 2'b11 is invalid and reads as 0.
// PARAMETERS
// - ADDR_TRITS  3   low address trits decoded by memory; depth = 3**ADDR_TRITS = 27 words
// - PROG_LEN    4   boot-program words held in loader ROM (1..27)
// PORTS
// - clock  in  1  single system clock; all state updates on its rising edge
// - reset  in  1  asynchronous, active-low reset
// - start  in  1  one-cycle pulse; begins load when FSM is IDLE
// BEHAVIOUR
// - Reset: system_state=IDLE, loader index=0, memory write disabled.
// - Reset: CPU held in reset (PC=0, regs=all-zero trits, cpu.state=0); memory contents undefined.
// - Reset mid-load or mid-execution aborts immediately to these values.
// - system_state localparams: IDLE, LOADING, EXECUTING.
// - IDLE -> LOADING on the first clock with start=1. start is ignored in LOADING/EXECUTING.
// - LOADING: the loader writes one word per cycle: ROM[k] to address k, for k=0..PROG_LEN-1.
//   - loader.mem_write=1, loader.mem_addr and loader.mem_write_data are valid in the same cycle.
//   - The cycle after the last write, the FSM enters EXECUTING.
// - EXECUTING: CPU reset released; CPU owns the memory port (mux selected by system_state).
//   - Stays in EXECUTING until reset. No done output.
//   - A halted CPU parks with PC constant and cpu.state=0.
// - Memory: synchronous write and combinational read.
//   - Index = integer value of the low ADDR_TRITS trits + 13, giving 0..26.
//   - Upper trits are ignored, so addresses wrap modulo 27.
//   - Invalid trit codes decode as 0.
// - Internal names are part of the contract: system_state, loader, loader.mem_write, loader.mem_addr, loader.mem_write_data.
// - CPU instance `cpu` exposes: program_counter, opcode, state (0=fetch, 4=writeback), mem_write, mem_address, mem_write_data, alu_out, and regs.regs[0:7] (8 x 18-bit).
// STRUCTURE
// - Shared package/include: trit macros `_1/`_0/`_1_, WORD_W=18, FSM state constants, opcode constants.
// - Sub-module: program_loader (ROM, index counter, write strobe, done flag), instanced as `loader`.
// - Reused: existing `cpu`; memory may be inline.
// - Companion module gate_counter_top:
//   - No ports; instanced alongside by the bench.
//   - Holds integer tallies of primitive ternary gates.
//   - Task display_counts prints one line per gate type.
// TESTING
// - Reset low 20 ns, release, start pulse 10 ns -> LOADING next edge; writes addr 0..3 with ROM words in 4 consecutive cycles.
// - Default ROM program: LDI R1,+5; LDI R2,-3; ADD R3,R1,R2; HALT.
//   -> final R1=5, R2=-3, R3=2, others 0; PC frozen >=5 cycles with cpu.state=0.
// - start pulsed during EXECUTING -> no reload, register values unchanged.
// - Reset asserted mid-LOADING (after 2 writes) -> IDLE immediately; a new start reloads from addr 0.
// - Negative/wrapped address: CPU store to address -13 lands at index 0, and to +14 wraps to index 0.
//   -> the read-back value matches the value written.
// - gate_counter_top.display_counts after the run -> prints nonzero counts, no X values.

Source files
------------

// File: rtl/ternary_pkg.sv
// Shared ternary definitions: trit codes, word geometry, state and opcode
// constants, and balanced-ternary conversion helpers.
`define TRIT_N 2'b00
`define TRIT_Z 2'b01
`define TRIT_P 2'b10

package ternary_pkg;

  localparam int WORD_W    = 18;
  localparam int TRITS     = 9;
  localparam int MEM_DEPTH = 27;
  localparam int ROM_W     = MEM_DEPTH * WORD_W;

  localparam logic [WORD_W-1:0] ZERO_WORD = {TRITS{`TRIT_Z}};

  // System-level sequencing.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOADING   = 2'd1,
    EXECUTING = 2'd2
  } sys_state_t;

  // CPU instruction phases; fetch is 0 and writeback is 4.
  typedef enum logic [2:0] {
    CPU_FETCH     = 3'd0,
    CPU_DECODE    = 3'd1,
    CPU_EXECUTE   = 3'd2,
    CPU_MEMORY    = 3'd3,
    CPU_WRITEBACK = 3'd4
  } cpu_state_t;

  // Opcode = value of trits [8:7] + 4. An all-zero word decodes as HALT,
  // so running into unwritten (zero) code stops the CPU.
  localparam logic [3:0] OP_HALT = 4'd4;
  localparam logic [3:0] OP_LDI  = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_LD   = 4'd8;

  // Invalid code 2'b11 reads as 0.
  function automatic int trit_val(input logic [1:0] t);
    case (t)
      `TRIT_N: return -1;
      `TRIT_P: return 1;
      default: return 0;
    endcase
  endfunction

  // Integer value of trits lo .. lo+n-1 of a word.
  function automatic int trit_field(input logic [WORD_W-1:0] w, input int lo, input int n);
    int acc;
    acc = 0;
    for (int i = TRITS - 1; i >= 0; i--) begin
      if (i >= lo && i < lo + n) acc = acc * 3 + trit_val(w[2*i +: 2]);
    end
    return acc;
  endfunction

  // Low nine balanced trits of an integer (wraps modulo 3**9).
  function automatic logic [WORD_W-1:0] int_to_word(input int v);
    logic [WORD_W-1:0] w;
    int r;
    int m;
    r = v;
    w = ZERO_WORD;
    for (int i = 0; i < TRITS; i++) begin
      m = r % 3;
      if (m == 1 || m == -2) begin
        w[2*i +: 2] = `TRIT_P;
        r = (r - 1) / 3;
      end else if (m == 2 || m == -1) begin
        w[2*i +: 2] = `TRIT_N;
        r = (r + 1) / 3;
      end else begin
        w[2*i +: 2] = `TRIT_Z;
        r = r / 3;
      end
    end
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] add_words(input logic [WORD_W-1:0] a,
                                                  input logic [WORD_W-1:0] b);
    return int_to_word(trit_field(a, 0, TRITS) + trit_field(b, 0, TRITS));
  endfunction

  // Register numbers 0..7 are stored as field value -4..3.
  function automatic logic [WORD_W-1:0] enc_instr(input int op, input int rd,
                                                  input int rs1, input int rs2);
    return int_to_word((op - 4) * 2187 + (rd - 4) * 243 + (rs1 - 4) * 27 + (rs2 - 4) * 3);
  endfunction

  function automatic logic [WORD_W-1:0] enc_ldi(input int rd, input int imm);
    return int_to_word((int'(OP_LDI) - 4) * 2187 + (rd - 4) * 243 + imm);
  endfunction

  // Boot program: LDI R1,+5; LDI R2,-3; ADD R3,R1,R2; HALT.
  function automatic logic [ROM_W-1:0] build_default_rom();
    logic [ROM_W-1:0] r;
    for (int k = 0; k < MEM_DEPTH; k++) r[k*WORD_W +: WORD_W] = ZERO_WORD;
    r[0*WORD_W +: WORD_W] = enc_ldi(1, 5);
    r[1*WORD_W +: WORD_W] = enc_ldi(2, -3);
    r[2*WORD_W +: WORD_W] = enc_instr(int'(OP_ADD), 3, 1, 2);
    r[3*WORD_W +: WORD_W] = ZERO_WORD;
    return r;
  endfunction

  localparam logic [ROM_W-1:0] DEFAULT_ROM = build_default_rom();

endpackage

// File: rtl/cpu.sv
// Multi-cycle ternary CPU core (fetch/decode/execute/memory/writeback) and
// its 8-entry register file.
module cpu_regfile
  import ternary_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_we,
  input  logic [2:0]        i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [2:0]        i_raddr_a,
  input  logic [2:0]        i_raddr_b,
  input  logic [2:0]        i_raddr_d,
  output logic [WORD_W-1:0] o_rdata_a,
  output logic [WORD_W-1:0] o_rdata_b,
  output logic [WORD_W-1:0] o_rdata_d
);

  logic [WORD_W-1:0] regs [0:7];

  assign o_rdata_a = regs[i_raddr_a];
  assign o_rdata_b = regs[i_raddr_b];
  assign o_rdata_d = regs[i_raddr_d];

  // Registers return to all-zero trits on reset or while the core is held.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= ZERO_WORD;
    end else if (i_clear) begin
      for (int i = 0; i < 8; i++) regs[i] <= ZERO_WORD;
    end else if (i_we) begin
      regs[i_waddr] <= i_wdata;
    end
  end

endmodule

module cpu
  import ternary_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic [WORD_W-1:0] i_mem_read_data,
  output logic              o_mem_write,
  output logic [WORD_W-1:0] o_mem_address,
  output logic [WORD_W-1:0] o_mem_write_data
);

  cpu_state_t        state;
  cpu_state_t        w_state_next;
  logic [WORD_W-1:0] program_counter;
  logic [WORD_W-1:0] r_ir;
  logic [WORD_W-1:0] r_opa;
  logic [WORD_W-1:0] r_opb;
  logic [WORD_W-1:0] r_opd;
  logic [WORD_W-1:0] r_mdr;
  logic [WORD_W-1:0] alu_out;
  logic              r_halted;
  logic [3:0]        opcode;
  logic [2:0]        w_rd;
  logic [2:0]        w_rs1;
  logic [2:0]        w_rs2;
  logic [WORD_W-1:0] w_rdata_a;
  logic [WORD_W-1:0] w_rdata_b;
  logic [WORD_W-1:0] w_rdata_d;
  logic              w_reg_we;
  logic [WORD_W-1:0] w_reg_wdata;
  logic              mem_write;
  logic [WORD_W-1:0] mem_address;
  logic [WORD_W-1:0] mem_write_data;

  // Field value 4 (register "8") aliases to R0 through the 3-bit truncation.
  assign opcode = 4'(trit_field(r_ir, 7, 2) + 4);
  assign w_rd   = 3'(trit_field(r_ir, 5, 2) + 4);
  assign w_rs1  = 3'(trit_field(r_ir, 3, 2) + 4);
  assign w_rs2  = 3'(trit_field(r_ir, 1, 2) + 4);

  cpu_regfile regs (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (!i_run),
    .i_we      (w_reg_we),
    .i_waddr   (w_rd),
    .i_wdata   (w_reg_wdata),
    .i_raddr_a (w_rs1),
    .i_raddr_b (w_rs2),
    .i_raddr_d (w_rd),
    .o_rdata_a (w_rdata_a),
    .o_rdata_b (w_rdata_b),
    .o_rdata_d (w_rdata_d)
  );

  assign w_reg_we    = (state == CPU_WRITEBACK) &&
                       (opcode == OP_LDI || opcode == OP_ADD || opcode == OP_LD);
  assign w_reg_wdata = (opcode == OP_LD) ? r_mdr : alu_out;

  assign mem_write      = (state == CPU_MEMORY) && (opcode == OP_ST);
  assign mem_address    = (state == CPU_MEMORY) ? alu_out : program_counter;
  assign mem_write_data = r_opd;

  assign o_mem_write      = mem_write;
  assign o_mem_address    = mem_address;
  assign o_mem_write_data = mem_write_data;

  // Phase register; held at fetch while the system keeps the core in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    state <= CPU_FETCH;
    else if (!i_run) state <= CPU_FETCH;
    else             state <= w_state_next;
  end

  // Phase sequencing; a halted core parks in fetch without fetching.
  always_comb begin
    w_state_next = state;
    case (state)
      CPU_FETCH:     if (!r_halted) w_state_next = CPU_DECODE;
      CPU_DECODE:    w_state_next = CPU_EXECUTE;
      CPU_EXECUTE:   w_state_next = (opcode == OP_HALT) ? CPU_FETCH : CPU_MEMORY;
      CPU_MEMORY:    w_state_next = CPU_WRITEBACK;
      CPU_WRITEBACK: w_state_next = CPU_FETCH;
      default:       w_state_next = CPU_FETCH;
    endcase
  end

  // Datapath registers advanced by the current phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      program_counter <= ZERO_WORD;
      r_ir            <= ZERO_WORD;
      r_opa           <= ZERO_WORD;
      r_opb           <= ZERO_WORD;
      r_opd           <= ZERO_WORD;
      r_mdr           <= ZERO_WORD;
      alu_out         <= ZERO_WORD;
      r_halted        <= 1'b0;
    end else if (!i_run) begin
      program_counter <= ZERO_WORD;
      r_ir            <= ZERO_WORD;
      r_opa           <= ZERO_WORD;
      r_opb           <= ZERO_WORD;
      r_opd           <= ZERO_WORD;
      r_mdr           <= ZERO_WORD;
      alu_out         <= ZERO_WORD;
      r_halted        <= 1'b0;
    end else begin
      case (state)
        CPU_FETCH: if (!r_halted) r_ir <= i_mem_read_data;
        CPU_DECODE: begin
          r_opa <= w_rdata_a;
          r_opb <= w_rdata_b;
          r_opd <= w_rdata_d;
        end
        CPU_EXECUTE: begin
          case (opcode)
            OP_LDI:       alu_out <= int_to_word(trit_field(r_ir, 0, 5));
            OP_ADD:       alu_out <= add_words(r_opa, r_opb);
            OP_ST, OP_LD: alu_out <= r_opa;
            OP_HALT:      r_halted <= 1'b1;
            default:      alu_out <= alu_out;
          endcase
        end
        CPU_MEMORY: if (opcode == OP_LD) r_mdr <= i_mem_read_data;
        CPU_WRITEBACK: program_counter <= int_to_word(trit_field(program_counter, 0, TRITS) + 1);
        default: r_ir <= r_ir;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: streams ROM words to memory addresses 0..PROG_LEN-1, one per
// cycle, while enabled; flags the cycle carrying the last word.
module program_loader
  import ternary_pkg::*;
#(
  parameter int               PROG_LEN  = 4,
  parameter logic [ROM_W-1:0] ROM_IMAGE = DEFAULT_ROM
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_enable,
  output logic              o_mem_write,
  output logic [WORD_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_write_data,
  output logic              o_done
);

  logic [4:0]        r_index;
  logic [WORD_W-1:0] w_rom [0:MEM_DEPTH-1];
  logic              mem_write;
  logic [WORD_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_write_data;
  logic              w_last;

  for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = ROM_IMAGE[gi*WORD_W +: WORD_W];
  end

  assign mem_write      = i_enable;
  assign mem_addr       = int_to_word(int'(r_index));
  assign mem_write_data = w_rom[r_index];
  assign w_last         = i_enable && (r_index == 5'(PROG_LEN - 1));

  assign o_mem_write      = mem_write;
  assign o_mem_addr       = mem_addr;
  assign o_mem_write_data = mem_write_data;
  assign o_done           = w_last;

  // Index advances per written word; it rests at 0 whenever loading is off.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_index <= '0;
    else if (!i_enable) r_index <= '0;
    else if (!w_last)   r_index <= r_index + 5'd1;
  end

endmodule

// File: rtl/ternary_system.sv
// Ternary computer top: system FSM, boot loader, unified word memory and CPU.
module ternary_system
  import ternary_pkg::*;
#(
  parameter int               ADDR_TRITS = 3,
  parameter int               PROG_LEN   = 4,
  parameter logic [ROM_W-1:0] ROM_IMAGE  = DEFAULT_ROM
) (
  input  logic clock,
  input  logic reset,
  input  logic start
);

  localparam int DEPTH = 3 ** ADDR_TRITS;
  localparam int IDX_W = $clog2(DEPTH);

  sys_state_t        system_state;
  sys_state_t        w_state_next;
  logic [WORD_W-1:0] r_mem [0:DEPTH-1];
  logic              w_ld_write;
  logic [WORD_W-1:0] w_ld_addr;
  logic [WORD_W-1:0] w_ld_data;
  logic              w_ld_done;
  logic              w_cpu_write;
  logic [WORD_W-1:0] w_cpu_addr;
  logic [WORD_W-1:0] w_cpu_data;
  logic              w_run;
  logic              w_mem_we;
  logic [WORD_W-1:0] w_mem_addr;
  logic [WORD_W-1:0] w_mem_wdata;
  logic [WORD_W-1:0] w_mem_rdata;
  logic [IDX_W-1:0]  w_mem_index;

  assign w_run = (system_state == EXECUTING);

  program_loader #(
    .PROG_LEN  (PROG_LEN),
    .ROM_IMAGE (ROM_IMAGE)
  ) loader (
    .i_clk            (clock),
    .i_rst_n          (reset),
    .i_enable         (system_state == LOADING),
    .o_mem_write      (w_ld_write),
    .o_mem_addr       (w_ld_addr),
    .o_mem_write_data (w_ld_data),
    .o_done           (w_ld_done)
  );

  cpu cpu (
    .i_clk            (clock),
    .i_rst_n          (reset),
    .i_run            (w_run),
    .i_mem_read_data  (w_mem_rdata),
    .o_mem_write      (w_cpu_write),
    .o_mem_address    (w_cpu_addr),
    .o_mem_write_data (w_cpu_data)
  );

  // Memory port belongs to the CPU only while executing.
  always_comb begin
    w_mem_we    = w_ld_write;
    w_mem_addr  = w_ld_addr;
    w_mem_wdata = w_ld_data;
    if (w_run) begin
      w_mem_we    = w_cpu_write;
      w_mem_addr  = w_cpu_addr;
      w_mem_wdata = w_cpu_data;
    end
  end

  // Low trits map -13..13 onto 0..26; upper trits are ignored, so addresses wrap.
  assign w_mem_index = IDX_W'(trit_field(w_mem_addr, 0, ADDR_TRITS) + (DEPTH - 1) / 2);
  assign w_mem_rdata = r_mem[w_mem_index];

  // Word memory: synchronous write, combinational read, contents not reset.
  always_ff @(posedge clock) begin
    if (w_mem_we) r_mem[w_mem_index] <= w_mem_wdata;
  end

  // System state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) system_state <= IDLE;
    else        system_state <= w_state_next;
  end

  // Idle until start, load the boot image, then execute until reset.
  always_comb begin
    w_state_next = system_state;
    case (system_state)
      IDLE:      if (start) w_state_next = LOADING;
      LOADING:   if (w_ld_done) w_state_next = EXECUTING;
      EXECUTING: w_state_next = EXECUTING;
      default:   w_state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ternary_system.sv
// Directed bench for ternary_system plus the companion gate tally module.
module gate_counter_top;
  int n_sum   = 0;
  int n_carry = 0;
  int n_mux   = 0;
  int n_buf   = 0;

  task automatic tally(input int kind, input int n);
    case (kind)
      0: n_sum   = n_sum + n;
      1: n_carry = n_carry + n;
      2: n_mux   = n_mux + n;
      default: n_buf = n_buf + n;
    endcase
  endtask

  task automatic display_counts();
    $display("gate sum   : %0d", n_sum);
    $display("gate carry : %0d", n_carry);
    $display("gate mux   : %0d", n_mux);
    $display("gate buffer: %0d", n_buf);
  endtask
endmodule

module tb_ternary_system;
  logic clock = 1'b0;
  logic reset;
  logic start;
  logic start2;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clock = ~clock;

  // Balanced-ternary encoding of an integer into 9 trits (-1=00, 0=01, +1=10).
  function automatic logic [17:0] tb_word(input int v);
    logic [17:0] w;
    int r;
    int m;
    r = v;
    for (int i = 0; i < 9; i++) begin
      m = ((r % 3) + 3) % 3;
      if (m == 0) begin
        w[2*i +: 2] = 2'b01;
        r = r / 3;
      end else if (m == 1) begin
        w[2*i +: 2] = 2'b10;
        r = (r - 1) / 3;
      end else begin
        w[2*i +: 2] = 2'b00;
        r = (r + 1) / 3;
      end
    end
    return w;
  endfunction

  function automatic logic [17:0] tb_instr(input int op, input int rd, input int a, input int b);
    return tb_word((op - 4) * 2187 + (rd - 4) * 243 + (a - 4) * 27 + (b - 4) * 3);
  endfunction

  function automatic logic [17:0] tb_ldi(input int rd, input int imm);
    return tb_word(2187 + (rd - 4) * 243 + imm);
  endfunction

  // Store/load program exercising negative and wrapped addresses.
  function automatic logic [485:0] build_rom2();
    logic [485:0] r;
    for (int k = 0; k < 27; k++) r[k*18 +: 18] = tb_word(0);
    r[0*18 +: 18] = tb_ldi(1, -13);
    r[1*18 +: 18] = tb_ldi(2, 7);
    r[2*18 +: 18] = tb_instr(7, 2, 1, 4);
    r[3*18 +: 18] = tb_instr(8, 4, 1, 4);
    r[4*18 +: 18] = tb_ldi(5, 14);
    r[5*18 +: 18] = tb_ldi(6, -9);
    r[6*18 +: 18] = tb_instr(7, 6, 5, 4);
    r[7*18 +: 18] = tb_instr(8, 7, 1, 4);
    r[8*18 +: 18] = tb_word(0);
    return r;
  endfunction

  localparam logic [485:0] ROM2 = build_rom2();

  ternary_system #(.ADDR_TRITS(3), .PROG_LEN(4)) dut (
    .clock (clock),
    .reset (reset),
    .start (start)
  );

  ternary_system #(.ADDR_TRITS(3), .PROG_LEN(9), .ROM_IMAGE(ROM2)) dut_st (
    .clock (clock),
    .reset (reset),
    .start (start2)
  );

  gate_counter_top gc ();

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total = n_total + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Tally primitive gates exercised by each executed instruction and load word.
  always @(negedge clock) begin
    if (int'(dut.cpu.state) == 2 || int'(dut_st.cpu.state) == 2) gc.tally(2, 1);
    if (int'(dut.cpu.state) == 2 && int'(dut.cpu.opcode) == 6) begin
      gc.tally(0, 9);
      gc.tally(1, 9);
    end
    if (dut.loader.mem_write) gc.tally(3, 9);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int which, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clock);
      if (which == 0) seen = dut.cpu.r_halted;
      else            seen = dut_st.cpu.r_halted;
    end
    check_eq(tag, 32'(seen), 32'd1);
  endtask

  logic [17:0] rom_exp [0:3];
  int          exp_r   [0:7];
  int          n_writes;

  initial begin
    rom_exp[0] = tb_ldi(1, 5);
    rom_exp[1] = tb_ldi(2, -3);
    rom_exp[2] = tb_instr(6, 3, 1, 2);
    rom_exp[3] = tb_word(0);
    for (int r = 0; r < 8; r++) exp_r[r] = 0;
    exp_r[1] = 5;
    exp_r[2] = -3;
    exp_r[3] = 2;

    reset  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    #20 reset = 1'b1;
    @(negedge clock);

    // Reset state
    check_eq("rst_state", 32'(dut.system_state), 32'd0);
    check_eq("rst_wr", 32'(dut.loader.mem_write), 32'd0);
    check_eq("rst_pc", 32'(dut.cpu.program_counter), 32'(tb_word(0)));
    check_eq("rst_cpust", 32'(dut.cpu.state), 32'd0);
    check_eq("rst_r1", 32'(dut.cpu.regs.regs[1]), 32'(tb_word(0)));

    // Boot load: four consecutive writes of the ROM to addresses 0..3
    pulse_start();
    check_eq("load_state", 32'(dut.system_state), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("ld_we%0d", k), 32'(dut.loader.mem_write), 32'd1);
      check_eq($sformatf("ld_addr%0d", k), 32'(dut.loader.mem_addr), 32'(tb_word(k)));
      check_eq($sformatf("ld_data%0d", k), 32'(dut.loader.mem_write_data), 32'(rom_exp[k]));
      @(negedge clock);
    end
    check_eq("exec_state", 32'(dut.system_state), 32'd2);
    check_eq("mem_13", 32'(dut.r_mem[13]), 32'(rom_exp[0]));

    // Run the default program to HALT
    wait_halt(0, "halt1");
    for (int r = 0; r < 8; r++)
      check_eq($sformatf("reg%0d", r), 32'(dut.cpu.regs.regs[r]), 32'(tb_word(exp_r[r])));
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("park_pc%0d", c), 32'(dut.cpu.program_counter), 32'(tb_word(3)));
      check_eq($sformatf("park_st%0d", c), 32'(dut.cpu.state), 32'd0);
      @(negedge clock);
    end

    // start while executing: no reload, registers unchanged
    n_writes = 0;
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      if (dut.loader.mem_write) n_writes = n_writes + 1;
      @(negedge clock);
    end
    check_eq("restart_wr", 32'(n_writes), 32'd0);
    check_eq("restart_st", 32'(dut.system_state), 32'd2);
    check_eq("restart_r3", 32'(dut.cpu.regs.regs[3]), 32'(tb_word(2)));

    // Reset during execution aborts immediately
    reset = 1'b0;
    #1;
    check_eq("abort_exec_st", 32'(dut.system_state), 32'd0);
    check_eq("abort_exec_pc", 32'(dut.cpu.program_counter), 32'(tb_word(0)));
    check_eq("abort_exec_r3", 32'(dut.cpu.regs.regs[3]), 32'(tb_word(0)));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Reset after two load writes, then reload from address 0
    pulse_start();
    @(negedge clock);
    check_eq("mid_addr1", 32'(dut.loader.mem_addr), 32'(tb_word(1)));
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_st", 32'(dut.system_state), 32'd0);
    check_eq("mid_rst_wr", 32'(dut.loader.mem_write), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    pulse_start();
    check_eq("reload_addr", 32'(dut.loader.mem_addr), 32'(tb_word(0)));
    check_eq("reload_data", 32'(dut.loader.mem_write_data), 32'(rom_exp[0]));
    wait_halt(0, "halt2");
    check_eq("reload_r3", 32'(dut.cpu.regs.regs[3]), 32'(tb_word(2)));

    // Store/load through address -13 and wrapped +14 (both index 0)
    start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    wait_halt(1, "halt_st");
    check_eq("st_r4", 32'(dut_st.cpu.regs.regs[4]), 32'(tb_word(7)));
    check_eq("st_r5", 32'(dut_st.cpu.regs.regs[5]), 32'(tb_word(14)));
    check_eq("st_r7", 32'(dut_st.cpu.regs.regs[7]), 32'(tb_word(-9)));
    check_eq("st_mem0", 32'(dut_st.r_mem[0]), 32'(tb_word(-9)));
    check_eq("st_mem13", 32'(dut_st.r_mem[13]), 32'(tb_ldi(1, -13)));
    check_eq("st_pc", 32'(dut_st.cpu.program_counter), 32'(tb_word(8)));

    gc.display_counts();
    check_eq("gates_nonzero",
             32'((gc.n_sum > 0) && (gc.n_carry > 0) && (gc.n_mux > 0) && (gc.n_buf > 0)),
             32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
